// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler
// Latches floor calls into a pending set, picks the next target with a SCAN
// (keep-direction) policy, offers it to the motion controller over a
// valid/ready handshake and holds the door open for DOOR_CYCLES cycles.
// Emergency stop overrides all scheduling.
// Optional feature macro: SCHED_EMERGENCY_RECALL_EN
//   defined   - HALT clears pending, ignores calls, and recalls the car to
//               floor 0 on release.
//   undefined - pending is kept and keeps accumulating through HALT.
module elevator_request_scheduler #(
    parameter int unsigned NUM_FLOORS  = 4,
    parameter int unsigned FLOOR_W     = 2,
    parameter int unsigned DOOR_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  car_moving,
    input  logic                  emergency_stop,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    input  logic                  target_ready,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  door_open,
    output logic                  busy
);

    localparam int unsigned      CNT_W    = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_TRAVEL,
        S_DOOR,
        S_HALT
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        dwell_cnt;

    logic [NUM_FLOORS-1:0]   cur_bit;
    logic [NUM_FLOORS-1:0]   tgt_bit;
    logic [NUM_FLOORS-1:0]   call_masked;
    logic [NUM_FLOORS-1:0]   pend_acc;
    logic                    here_hit;
    logic                    up_found;
    logic                    dn_found;
    logic [FLOOR_W-1:0]      up_floor;
    logic [FLOOR_W-1:0]      dn_floor;
    logic                    fwd_found;
    logic                    rev_found;
    logic [FLOOR_W-1:0]      fwd_floor;
    logic [FLOOR_W-1:0]      rev_floor;

    // One-hot floor decodes and the call set to merge into pending this cycle
    always_comb begin
        cur_bit     = NUM_FLOORS'(1) << current_floor;
        tgt_bit     = NUM_FLOORS'(1) << target_floor;
        call_masked = call_req;
        if (state == S_DOOR) begin
            call_masked = call_req & ~tgt_bit;
        end
        pend_acc = pending | call_masked;
        here_hit = ((pending & cur_bit) != '0) && !car_moving;
    end

    // Nearest pending floor above (lowest index) and below (highest index)
    always_comb begin
        up_found = 1'b0;
        dn_found = 1'b0;
        up_floor = '0;
        dn_floor = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) > current_floor) && !up_found) begin
                up_found = 1'b1;
                up_floor = FLOOR_W'(i);
            end
            if (pending[i] && (FLOOR_W'(i) < current_floor)) begin
                dn_found = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
        fwd_found = dir_up ? up_found : dn_found;
        fwd_floor = dir_up ? up_floor : dn_floor;
        rev_found = dir_up ? dn_found : up_found;
        rev_floor = dir_up ? dn_floor : up_floor;
    end

    // Scheduler FSM with registered outputs and the pending-call set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            target_floor <= '0;
            target_valid <= 1'b0;
            pending      <= '0;
            dir_up       <= 1'b1;
            door_open    <= 1'b0;
            busy         <= 1'b0;
            dwell_cnt    <= '0;
        end else if (emergency_stop) begin
            // Emergency wins over any handshake or door exit on the same edge
            state        <= S_HALT;
            busy         <= 1'b1;
            target_valid <= 1'b0;
            door_open    <= 1'b0;
            dwell_cnt    <= '0;
`ifdef SCHED_EMERGENCY_RECALL_EN
            pending      <= '0;
`else
            pending      <= pend_acc;
`endif
        end else begin
            pending <= pend_acc;
            case (state)
                S_IDLE: begin
                    if (here_hit) begin
                        state        <= S_DOOR;
                        busy         <= 1'b1;
                        target_floor <= current_floor;
                        door_open    <= 1'b1;
                        dwell_cnt    <= '0;
                        pending      <= pend_acc & ~cur_bit;
                    end else if (fwd_found) begin
                        state        <= S_DISPATCH;
                        busy         <= 1'b1;
                        target_floor <= fwd_floor;
                        target_valid <= 1'b1;
                    end else if (rev_found) begin
                        state        <= S_DISPATCH;
                        busy         <= 1'b1;
                        dir_up       <= ~dir_up;
                        target_floor <= rev_floor;
                        target_valid <= 1'b1;
                    end
                end
                S_DISPATCH: begin
                    if (target_ready) begin
                        state        <= S_TRAVEL;
                        target_valid <= 1'b0;
                    end
                end
                S_TRAVEL: begin
                    if ((current_floor == target_floor) && !car_moving) begin
                        state     <= S_DOOR;
                        door_open <= 1'b1;
                        dwell_cnt <= '0;
                        pending   <= pend_acc & ~tgt_bit;
                    end
                end
                S_DOOR: begin
                    if (dwell_cnt == CNT_LAST) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        door_open <= 1'b0;
                        dwell_cnt <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + CNT_W'(1);
                    end
                end
                S_HALT: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
`ifdef SCHED_EMERGENCY_RECALL_EN
                    pending <= NUM_FLOORS'(1);
`endif
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
